// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async_fifo write port among NUM_REQ requesters
//
// Grants one requester at a time for a burst of up to MAX_BURST beats and forwards its
// beats to the FIFO combinationally. Every release spends one IDLE cycle, which leaves
// time for the FIFO full flag to settle before the next owner starts.
//
// Ports:
//   clk_i         write-domain clock
//   rst_n_i       asynchronous active-low reset
//   req_valid_i   per-requester beat valid
//   req_last_i    per-requester last beat of burst, qualified by valid
//   req_data_i    requester r data at [r*WIDTH +: WIDTH]
//   req_ready_o   beat accepted when valid & ready; only the owner can be ready
//   grant_o       registered one-hot owner, zero when idle
//   fifo_full_i   async_fifo full flag
//   fifo_wr_en_o  async_fifo write enable
//   fifo_wdata_o  async_fifo write data, zero when not writing
//   busy_o        high while a requester owns the port
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       grant_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    output logic                     busy_o
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, XFER} state_t;
    state_t state, state_nxt;
    logic [GW-1:0] own, last_grant, pick;
    logic [CW-1:0] beat_cnt;
    logic xfer, beat, done;
    assign xfer = state == XFER;
    assign beat = xfer & req_valid_i[own] & ~fifo_full_i;
    // Release on the owner's last beat, on the burst cap, or as soon as the owner stops
    // offering data (that last case applies even while the FIFO is full).
    assign done = xfer & (~req_valid_i[own] |
                          (beat & (req_last_i[own] | beat_cnt == CW'(MAX_BURST - 1))));
    assign busy_o       = xfer;
    assign fifo_wr_en_o = beat;
    assign fifo_wdata_o = beat ? req_data_i[own*WIDTH +: WIDTH] : '0;
    assign req_ready_o  = (xfer & ~fifo_full_i) ? NUM_REQ'(1) << own : '0;
    // Scan last_grant+1, +2, ... ; walking from the farthest offset down lets the
    // nearest valid requester overwrite the others.
    always_comb begin
        pick = last_grant;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req_valid_i[GW'((int'(last_grant) + i) % NUM_REQ)])
                pick = GW'((int'(last_grant) + i) % NUM_REQ);
    end
    always_comb begin
        state_nxt = xfer ? (done ? IDLE : XFER) : (|req_valid_i ? XFER : IDLE);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            grant_o    <= '0;
            own        <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else if (!xfer) begin
            if (|req_valid_i) begin
                own      <= pick;
                grant_o  <= NUM_REQ'(1) << pick;
                beat_cnt <= '0;
            end
        end else if (done) begin
            grant_o    <= '0;
            last_grant <= own;
            beat_cnt   <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(grant_o));
    a_no_write_full: assert property (@(posedge clk_i) disable iff (!rst_n_i) fifo_wr_en_o |-> !fifo_full_i);
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(req_ready_o));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench with producer models and a FIFO-order scoreboard
module tb_fifo_wr_arbiter;
    localparam int W = 4;
    localparam int N = 4;
    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic [N-1:0]   req_valid_i, req_last_i, req_ready_o, grant_o;
    logic [N*W-1:0] req_data_i;
    logic           fifo_full_i, fifo_wr_en_o, busy_o;
    logic [W-1:0]   fifo_wdata_o;
    typedef struct {
        logic       full;
        logic [3:0] grant;
        logic [3:0] ready;
        logic       wr;
        logic [3:0] data;
        logic       busy;
    } vec_t;
    vec_t       tbl[16];
    logic [3:0] pdat[N][8];
    logic       plast[N][8];
    int         phead[N], plen[N];
    logic [7:0] sb[$];
    logic [N-1:0] acc;
    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
        .req_data_i(req_data_i), .req_ready_o(req_ready_o), .grant_o(grant_o),
        .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_wdata_o(fifo_wdata_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [3:0] d, input logic l);
        if (phead[r] == plen[r]) begin
            phead[r] = 0;
            plen[r]  = 0;
        end
        pdat[r][plen[r]]  = d;
        plast[r][plen[r]] = l;
        plen[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            logic v;
            v = phead[r] < plen[r];
            req_valid_i[r]         = v;
            req_last_i[r]          = v ? plast[r][phead[r]] : 1'b0;
            req_data_i[r*W +: W]   = v ? pdat[r][phead[r]] : 4'h0;
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        acc = req_valid_i & req_ready_o;
        @(posedge clk_i);
        #1;
        for (int r = 0; r < N; r++) if (acc[r]) phead[r]++;
        drive();
        #1;
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < N; r++) if (phead[r] < plen[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_empty(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (all_empty() && grant_o == '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_drain"}, 32'(ok), 32'(1));
    endtask

    // FIFO side: every written beat must match the next expected {owner, data}.
    always @(negedge clk_i) begin
        if (fifo_wr_en_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_beat: got %0h expected no write", {grant_o, fifo_wdata_o});
            end else begin
                chk("sb_beat", 32'({grant_o, fifo_wdata_o}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        fifo_full_i = 1'b0;
        for (int r = 0; r < N; r++) begin
            phead[r] = 0;
            plen[r]  = 0;
        end
        for (int j = 0; j < 16; j++) tbl[j] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'h0, 1'b0};
        tbl[0]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'h1, 1'b1};
        tbl[2]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'h3, 1'b1};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'h5, 1'b1};
        tbl[6]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'h7, 1'b1};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'h2, 1'b1};
        tbl[10] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'h4, 1'b1};
        tbl[12] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'h6, 1'b1};
        tbl[14] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'h8, 1'b1};

        // reset held with every requester valid, then round-robin with last on every beat
        for (int r = 0; r < N; r++) begin
            push(r, 4'(2*r + 1), 1'b1);
            push(r, 4'(2*r + 2), 1'b1);
        end
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < N; r++) sb.push_back({4'(1 << r), 4'(2*r + 1 + k)});
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_grant", 32'(grant_o), 32'(0));
        chk("rst_ready", 32'(req_ready_o), 32'(0));
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_wdata", 32'(fifo_wdata_o), 32'(0));
        rst_n_i = 1'b1;
        for (int j = 0; j < 16; j++) begin
            fifo_full_i = tbl[j].full;
            tick();
            chk($sformatf("rr%0d_grant", j), 32'(grant_o), 32'(tbl[j].grant));
            chk($sformatf("rr%0d_ready", j), 32'(req_ready_o), 32'(tbl[j].ready));
            chk($sformatf("rr%0d_wr_en", j), 32'(fifo_wr_en_o), 32'(tbl[j].wr));
            chk($sformatf("rr%0d_wdata", j), 32'(fifo_wdata_o), 32'(tbl[j].data));
            chk($sformatf("rr%0d_busy", j), 32'(busy_o), 32'(tbl[j].busy));
        end

        // burst cap: req1 sends 6 beats, gets 4, others are served, then beats 5-6
        for (int k = 0; k < 6; k++) begin
            push(1, 4'(9 + k), k == 5);
            if (k < 4) sb.push_back({4'b0010, 4'(9 + k)});
        end
        drive();
        tick();
        chk("cap_grant", 32'(grant_o), 32'(4'b0010));
        push(2, 4'h3, 1'b1);
        push(0, 4'h5, 1'b1);
        sb.push_back({4'b0100, 4'h3});
        sb.push_back({4'b0001, 4'h5});
        sb.push_back({4'b0010, 4'hD});
        sb.push_back({4'b0010, 4'hE});
        drive();
        run_until_empty("cap");

        // full stall for three edges in the middle of req2's burst
        for (int k = 0; k < 4; k++) begin
            push(2, 4'(k + 1), k == 3);
            sb.push_back({4'b0100, 4'(k + 1)});
        end
        push(3, 4'hF, 1'b1);
        sb.push_back({4'b1000, 4'hF});
        drive();
        tick();
        chk("stall_grant", 32'(grant_o), 32'(4'b0100));
        tick();
        tick();
        fifo_full_i = 1'b1;
        #1;
        chk("stall_ready_now", 32'(req_ready_o), 32'(0));
        chk("stall_wr_en_now", 32'(fifo_wr_en_o), 32'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_grant", i), 32'(grant_o), 32'(4'b0100));
            chk($sformatf("stall%0d_ready", i), 32'(req_ready_o), 32'(0));
            chk($sformatf("stall%0d_wr_en", i), 32'(fifo_wr_en_o), 32'(0));
            chk($sformatf("stall%0d_busy", i), 32'(busy_o), 32'(1));
        end
        fifo_full_i = 1'b0;
        run_until_empty("stall");

        // owner drop: req2 stops after two beats, req3 wins over req0 next
        push(2, 4'h6, 1'b0);
        push(2, 4'h7, 1'b0);
        sb.push_back({4'b0100, 4'h6});
        sb.push_back({4'b0100, 4'h7});
        drive();
        tick();
        chk("drop_grant", 32'(grant_o), 32'(4'b0100));
        push(3, 4'h8, 1'b1);
        push(0, 4'h9, 1'b1);
        sb.push_back({4'b1000, 4'h8});
        sb.push_back({4'b0001, 4'h9});
        drive();
        tick();
        tick();
        chk("drop_hold_grant", 32'(grant_o), 32'(4'b0100));
        chk("drop_hold_wr_en", 32'(fifo_wr_en_o), 32'(0));
        tick();
        chk("drop_idle_grant", 32'(grant_o), 32'(0));
        chk("drop_idle_busy", 32'(busy_o), 32'(0));
        tick();
        chk("drop_next_grant", 32'(grant_o), 32'(4'b1000));
        run_until_empty("drop");

        // asynchronous reset between edges in the middle of req1's burst
        for (int k = 0; k < 4; k++) push(1, 4'(10 + k), k == 3);
        sb.push_back({4'b0010, 4'hA});
        drive();
        tick();
        chk("arst_pre_grant", 32'(grant_o), 32'(4'b0010));
        tick();
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("arst_grant", 32'(grant_o), 32'(0));
        chk("arst_wr_en", 32'(fifo_wr_en_o), 32'(0));
        chk("arst_ready", 32'(req_ready_o), 32'(0));
        chk("arst_busy", 32'(busy_o), 32'(0));
        chk("arst_wdata", 32'(fifo_wdata_o), 32'(0));
        for (int r = 0; r < N; r++) phead[r] = plen[r];
        push(0, 4'h1, 1'b1);
        push(1, 4'h2, 1'b1);
        sb.push_back({4'b0001, 4'h1});
        sb.push_back({4'b0010, 4'h2});
        drive();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        tick();
        chk("arst_prio_grant", 32'(grant_o), 32'(4'b0001));
        run_until_empty("arst");

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
